// File: rtl/l_sync_ctrl_pkg.sv
// rtl/l_sync_ctrl_pkg.sv - shared constants and state encoding for the long-preamble sync controller
package l_sync_ctrl_pkg;

    localparam int P_MAG_W   = 16;
    localparam int P_IDX_W   = 10;
    localparam int P_N_TAPS  = 16;   // 32-bit I/Q weight buses of 2-bit sign weights
    localparam int P_SPACING = 64;
    localparam int P_TOL     = 1;
    localparam int P_TIMEOUT = 320;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_FILL   = 3'd2;
    localparam state_t ST_SEARCH = 3'd3;
    localparam state_t ST_GAP    = 3'd4;

    function automatic logic is_corr_state(input state_t s);
        return (s == ST_FILL) || (s == ST_SEARCH) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/l_sync_ctrl_if.sv
// rtl/l_sync_ctrl_if.sv - arm/magnitude inputs and correlator/result outputs of the sync controller
interface l_sync_ctrl_if
    import l_sync_ctrl_pkg::*;
#(
    parameter int MAG_W = P_MAG_W,
    parameter int IDX_W = P_IDX_W
);
    logic             start;
    logic             mag_valid;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] threshold;
    logic             corr_clr;
    logic             corr_en;
    logic             busy;
    logic             lts_found;
    logic [IDX_W-1:0] lts_index;
    logic             timeout;

    modport master (
        output start, mag_valid, mag, threshold,
        input  corr_clr, corr_en, busy, lts_found, lts_index, timeout
    );

    modport slave (
        input  start, mag_valid, mag, threshold,
        output corr_clr, corr_en, busy, lts_found, lts_index, timeout
    );

endinterface

// File: rtl/l_sync_sample_cnt.sv
// rtl/l_sync_sample_cnt.sv - saturating beat counter with clear, exposing the value including the current beat
module l_sync_sample_cnt #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt_nxt
);
    localparam logic [W-1:0] C_MAX = '1;
    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] r_cnt;

    // o_cnt_nxt is the index the current beat would carry, so callers compare against it directly
    assign o_cnt_nxt = (r_cnt == C_MAX) ? C_MAX : r_cnt + C_ONE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/l_sync_ctrl.sv
// rtl/l_sync_ctrl.sv - sequences the long-preamble correlator and qualifies two peaks one symbol apart
module l_sync_ctrl
    import l_sync_ctrl_pkg::*;
#(
    parameter int MAG_W   = P_MAG_W,
    parameter int IDX_W   = P_IDX_W,
    parameter int N_TAPS  = P_N_TAPS,
    parameter int SPACING = P_SPACING,
    parameter int TOL     = P_TOL,
    parameter int TIMEOUT = P_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    l_sync_ctrl_if.slave io_sync
);
    localparam logic [IDX_W-1:0] C_FILL   = IDX_W'(N_TAPS);
    localparam logic [IDX_W-1:0] C_TMO    = IDX_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] C_GAP_LO = IDX_W'(SPACING - TOL);
    localparam logic [IDX_W-1:0] C_GAP_HI = IDX_W'(SPACING + TOL);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MAG_W-1:0] r_thr;
    logic [IDX_W-1:0] r_index;
    logic             r_corr_clr;
    logic             r_corr_en;
    logic             r_busy;
    logic             r_found;
    logic             r_timeout;

    logic             w_beat;
    logic             w_hit;
    logic             w_found;
    logic             w_timeout;
    logic             w_smp_clr;
    logic             w_smp_en;
    logic             w_gap_clr;
    logic             w_gap_en;
    logic [IDX_W-1:0] w_smp_nxt;
    logic [IDX_W-1:0] w_gap_nxt;

    assign w_beat    = io_sync.mag_valid;
    assign w_hit     = (io_sync.mag >= r_thr);
    assign w_gap_clr = (r_state != ST_GAP);

    l_sync_sample_cnt #(.W(IDX_W)) u_smp_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_smp_clr),
        .i_en      (w_smp_en),
        .o_cnt_nxt (w_smp_nxt)
    );

    l_sync_sample_cnt #(.W(IDX_W)) u_gap_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_gap_clr),
        .i_en      (w_gap_en),
        .o_cnt_nxt (w_gap_nxt)
    );

    // Start overrides everything, which is also what suppresses a same-cycle Found/Timeout
    always_comb begin
        w_state_nxt = r_state;
        w_found     = 1'b0;
        w_timeout   = 1'b0;
        w_smp_clr   = 1'b0;
        w_smp_en    = 1'b0;
        w_gap_en    = 1'b0;
        if (io_sync.start) begin
            w_state_nxt = ST_CLEAR;
            w_smp_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: w_state_nxt = ST_FILL;
                ST_FILL: begin
                    if (w_beat) begin
                        w_smp_en = 1'b1;
                        if (w_smp_nxt == C_TMO) begin
                            w_timeout   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_smp_nxt == C_FILL) begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (w_beat) begin
                        w_smp_en = 1'b1;
                        if (w_smp_nxt == C_TMO) begin
                            w_timeout   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_hit) begin
                            w_state_nxt = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_beat) begin
                        w_smp_en = 1'b1;
                        w_gap_en = 1'b1;
                        if (w_hit && (w_gap_nxt >= C_GAP_LO) && (w_gap_nxt <= C_GAP_HI)) begin
                            w_found     = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_smp_nxt == C_TMO) begin
                            w_timeout   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_gap_nxt >= C_GAP_HI) begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_thr      <= '0;
            r_index    <= '0;
            r_corr_clr <= 1'b0;
            r_corr_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_found    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_corr_clr <= (w_state_nxt == ST_CLEAR);
            r_corr_en  <= is_corr_state(w_state_nxt);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_found    <= w_found;
            r_timeout  <= w_timeout;
            if (io_sync.start) begin
                r_thr   <= io_sync.threshold;
                r_index <= '0;
            end else if (w_found) begin
                r_index <= w_smp_nxt;
            end
        end
    end

    assign io_sync.corr_clr  = r_corr_clr;
    assign io_sync.corr_en   = r_corr_en;
    assign io_sync.busy      = r_busy;
    assign io_sync.lts_found = r_found;
    assign io_sync.lts_index = r_index;
    assign io_sync.timeout   = r_timeout;

endmodule
